// File: rtl/ingress_classifier_if.sv
// Ingress/egress bus of the ingress classifier.
//   data_in/valid_in/ready_out : upstream byte stream with valid/ready handshake
//   almost_full                : per-queue back-pressure from the four downstream FIFOs
//   push/data_out              : one-hot FIFO write strobe and the byte being written
// slave modport is the classifier; master modport is the surrounding environment.
interface ingress_classifier_if;
  localparam int unsigned DW = 8;
  localparam int unsigned NQ = 4;

  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_out;
  logic [NQ-1:0] almost_full;
  logic [NQ-1:0] push;
  logic [DW-1:0] data_out;

  modport slave (
    input  data_in, valid_in, almost_full,
    output ready_out, push, data_out
  );

  modport master (
    output data_in, valid_in, almost_full,
    input  ready_out, push, data_out
  );
endinterface

// File: rtl/ingress_classifier.sv
// Ingress classifier: steers length-prefixed packets into one of four FIFOs.
// The header byte carries {dest[1:0], len[5:0]}. The header is held until the
// destination FIFO has room, then forwarded together with its len payload bytes.
// A packet whose destination stays almost-full for WAIT_MAX cycles, or whose
// len is zero, is dropped.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : ingress_classifier_if.slave (stream in, FIFO strobes out)
//   busy        : high whenever the classifier is not idle
//   drop_count  : saturating dropped-packet count
// Optional feature: define DROP_COUNTER_EN to build the drop counter;
// without it drop_count is tied to zero.
module ingress_classifier #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ingress_classifier_if.slave   bus,
  output logic                  busy,
  output logic [7:0]            drop_count
);

  localparam int unsigned DW = 8;
  localparam int unsigned NQ = 4;
  localparam int unsigned QW = 2;
  localparam int unsigned LW = 6;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [QW-1:0] dest;
    logic [LW-1:0] len;
  } hdr_t;

  typedef enum logic [1:0] {IDLE, HOLD, PASS, DROP} state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] dest_q, dest_d;
  logic [LW-1:0] len_q, len_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [NQ-1:0] push_q, push_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          rdy_en_q;
  logic          ready_c;
  logic          drop_evt;
  logic          af_dest;
  logic [NQ-1:0] dest_oh;
  hdr_t          hdr;

  assign hdr     = hdr_t'(bus.data_in);
  assign af_dest = bus.almost_full[dest_q];
  assign dest_oh = NQ'(NQ'(1) << dest_q);

  // ready_out is combinational: in PASS it must follow almost_full in the same cycle.
  assign bus.ready_out = ready_c;
  assign bus.push      = push_q;
  assign bus.data_out  = dout_q;
  assign busy          = (state_q != IDLE);

  // Next-state and datapath decode.
  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    len_d    = len_q;
    wait_d   = wait_q;
    push_d   = '0;
    dout_d   = dout_q;
    ready_c  = 1'b0;
    drop_evt = 1'b0;

    case (state_q)
      IDLE: begin
        // rdy_en_q keeps ready low until the first edge after reset release.
        ready_c = rdy_en_q;
        if (bus.valid_in && ready_c) begin
          dest_d = hdr.dest;
          len_d  = hdr.len;
          wait_d = '0;
          if (hdr.len == '0) begin
            drop_evt = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (!af_dest) begin
          push_d  = dest_oh;
          dout_d  = {dest_q, len_q};
          state_d = PASS;
        end else begin
          wait_d = wait_q + CW'(1);
          if (wait_d == CW'(WAIT_MAX)) begin
            state_d = DROP;
          end
        end
      end

      PASS: begin
        ready_c = ~af_dest;
        if (bus.valid_in && ready_c) begin
          push_d = dest_oh;
          dout_d = bus.data_in;
          len_d  = len_q - LW'(1);
          if (len_q == LW'(1)) begin
            state_d = IDLE;
          end
        end
      end

      DROP: begin
        ready_c = 1'b1;
        if (bus.valid_in) begin
          len_d = len_q - LW'(1);
          if (len_q == LW'(1)) begin
            state_d  = IDLE;
            drop_evt = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dest_q   <= '0;
      len_q    <= '0;
      wait_q   <= '0;
      push_q   <= '0;
      dout_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      len_q    <= len_d;
      wait_q   <= wait_d;
      push_q   <= push_d;
      dout_q   <= dout_d;
      rdy_en_q <= 1'b1;
    end
  end

`ifdef DROP_COUNTER_EN
  logic [7:0] drop_q;

  // Saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop_evt && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_count = drop_q;
`else
  logic unused_drop_evt;

  assign unused_drop_evt = drop_evt;
  assign drop_count      = '0;
`endif

endmodule

// File: tb/tb_ingress_classifier.sv
// Testbench for ingress_classifier: directed scenarios plus randomized packets
// checked against a packet-level model (expected FIFO writes and drop totals).
module tb_ingress_classifier;
  localparam int unsigned WAIT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [7:0] drop_count;

  ingress_classifier_if bus();

  ingress_classifier #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_q[$];     // expected FIFO writes: {push one-hot, byte}
  int          exp_drops;    // packets dropped since last reset
  logic [1:0]  cur_dest;
  int          af_hi;        // remaining cycles almost_full[cur_dest] is held high
  logic        s_ready;
  logic        s_acc;
  int          run;
  int          max_run;
  logic [7:0]  pay[64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_dc();
`ifdef DROP_COUNTER_EN
    return (exp_drops > 255) ? 32'd255 : 32'(exp_drops);
`else
    return 32'd0;
`endif
  endfunction

  task automatic apply_af();
    bus.almost_full = 4'($urandom);
    bus.almost_full[cur_dest] = (af_hi > 0);
  endtask

  // One clock: sample at negedge, compare any FIFO write, then update almost_full.
  task automatic step();
    logic [11:0] e;
    @(negedge clk);
    s_ready = bus.ready_out;
    s_acc   = bus.valid_in & bus.ready_out;
    if (bus.push != 4'd0) begin
      run++;
      if (run > max_run) max_run = run;
      chk("push_onehot", $countones(bus.push), 1);
      if (exp_q.size() == 0) begin
        chk("push_unexpected", {bus.push, bus.data_out}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("push_data", {bus.push, bus.data_out}, e);
      end
    end else begin
      run = 0;
    end
    @(posedge clk);
    #1;
    if (af_hi > 0) af_hi--;
    apply_af();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.data_in  = b;
    bus.valid_in = 1'b1;
    do begin
      step();
      n++;
    end while (!s_acc && n < 300);
    if (!s_acc) chk("accept_timeout", 0, 1);
    bus.valid_in = 1'b0;
    bus.data_in  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    step();
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    chk("idle_busy", busy, 0);
    chk("idle_queue_empty", exp_q.size(), 0);
    chk("drop_count", drop_count, exp_dc());
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    af_hi        = 0;
    exp_q.delete();
    exp_drops    = 0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic void fill_random(input int len);
    for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
  endfunction

  // Send header h and pay[0..len-1]; k = cycles the destination stays almost-full
  // after the header. k >= WAIT_MAX or len == 0 means the packet is dropped.
  task automatic send_pkt(input logic [7:0] h, input int k, input bit stalls);
    int         len;
    bit         drop;
    logic [3:0] oh;
    len      = int'(h[5:0]);
    drop     = (len == 0) || (k >= int'(WAIT_MAX));
    oh       = 4'(4'd1 << h[7:6]);
    cur_dest = h[7:6];
    if (!drop) begin
      exp_q.push_back({oh, h});
      for (int i = 0; i < len; i++) exp_q.push_back({oh, pay[i]});
    end
    send_byte(h);
    af_hi = (len == 0) ? 0 : k;
    apply_af();
    for (int i = 0; i < len; i++) begin
      if (stalls && !drop && i > 0 && $urandom_range(3) == 0) begin
        af_hi = int'($urandom_range(3, 1));
        apply_af();
      end
      if (stalls) repeat ($urandom_range(1)) step();
      send_byte(pay[i]);
    end
    if (drop) exp_drops++;
    wait_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] h;
    int         len;
    int         k;
    bus.data_in     = 8'd0;
    bus.valid_in    = 1'b0;
    bus.almost_full = 4'd0;
    cur_dest        = 2'd0;
    af_hi           = 0;
    run             = 0;
    max_run         = 0;
    exp_drops       = 0;
    rst_n           = 1'b0;

    // Reset values
    #2;
    chk("rst_push", bus.push, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.ready_out, 0);
    chk("rst_drop_count", drop_count, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", bus.ready_out, 1);

    // Queue 2, three bytes, no back-pressure: four back-to-back writes
    pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3;
    max_run = 0;
    send_pkt(8'h83, 0, 1'b0);
    chk("back_to_back_writes", max_run, 4);

    // Queue 1 held almost-full for WAIT_MAX cycles: dropped
    fill_random(2);
    send_pkt(8'h42, int'(WAIT_MAX), 1'b0);

    // One cycle short of the limit: still forwarded
    fill_random(2);
    send_pkt(8'h02, int'(WAIT_MAX) - 1, 1'b0);

    // Queue 3 stalled mid-packet for 5 cycles, no drop
    cur_dest = 2'd3;
    fill_random(4);
    exp_q.push_back({4'b1000, 8'hC4});
    for (int i = 0; i < 4; i++) exp_q.push_back({4'b1000, pay[i]});
    send_byte(8'hC4);
    af_hi = 0;
    apply_af();
    send_byte(pay[0]);
    send_byte(pay[1]);
    af_hi = 5;
    apply_af();
    repeat (5) begin
      step();
      chk("stall_ready_low", s_ready, 0);
    end
    send_byte(pay[2]);
    send_byte(pay[3]);
    wait_idle();

    // Zero-length header is a drop; next header starts a new packet
    send_pkt(8'h00, 0, 1'b0);
    pay[0] = 8'h55;
    send_pkt(8'h01, 0, 1'b0);

    // Reset mid-packet
    cur_dest = 2'd1;
    af_hi = 0;
    apply_af();
    exp_q.push_back({4'b0010, 8'h43});
    send_byte(8'h43);
    send_byte(8'h11);
    rst_n = 1'b0;
    #1;
    chk("midrst_push", bus.push, 0);
    chk("midrst_data_out", bus.data_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", bus.ready_out, 0);
    chk("midrst_drop_count", drop_count, 0);
    exp_q.delete();
    exp_drops = 0;
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_ready_after", bus.ready_out, 1);
    pay[0] = 8'h3C;
    send_pkt(8'h81, 0, 1'b0);

    // Randomized packets with stalls, idle gaps and timeouts
    for (int p = 0; p < 40; p++) begin
      len = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(12, 1));
      k   = ($urandom_range(4) == 0) ? int'(WAIT_MAX) : int'($urandom_range(WAIT_MAX - 1));
      h   = {2'($urandom), 6'(len)};
      fill_random(len);
      send_pkt(h, k, 1'b1);
    end

    // 256 zero-length headers: counter saturates
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cur_dest = 2'($urandom);
      send_byte({cur_dest, 6'd0});
      exp_drops++;
    end
    step();
    chk("drop_saturate", drop_count, exp_dc());
    chk("drop_saturate_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
